// File: rtl/pll_mdrp_pkg.sv
// Shared opcodes, lock FSM states and address helpers for the MDRP responder.
package pll_mdrp_pkg;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ADDR  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef enum logic [1:0] {
        LK_HOLD   = 2'd0,
        LK_SETTLE = 2'd1,
        LK_LOCKED = 2'd2
    } lock_state_e;

    // Highest address of the register file is the read-only STATUS register.
    function automatic int unsigned status_addr(input int unsigned addr_w);
        return (32'd1 << addr_w) - 32'd1;
    endfunction

endpackage

// File: rtl/pll_mdrp_lock_timer.sv
// Emulated PLL lock: held off by pll_reset, restarted by relock, asserts
// after LOCK_CYCLES edges of uninterrupted settling.
module pll_mdrp_lock_timer
    import pll_mdrp_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 64
) (
    input  logic mdclk,
    input  logic reset,
    input  logic pll_reset,
    input  logic relock,
    output logic lock
);

    localparam int unsigned CNT_W = (LOCK_CYCLES > 2) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    lock_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_d;

    // State, counter and registered lock flag.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            state_q <= LK_SETTLE;
            cnt_q   <= '0;
            lock    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lock    <= lock_d;
        end
    end

    // Next state: pll_reset beats relock, relock beats reaching the settle end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lock_d  = 1'b0;
        case (state_q)
            LK_HOLD: begin
                if (!pll_reset) begin
                    state_d = LK_SETTLE;
                    cnt_d   = '0;
                end
            end
            LK_SETTLE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = LK_LOCKED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LK_LOCKED: begin
                state_d = LK_LOCKED;
            end
            default: begin
                state_d = LK_HOLD;
                cnt_d   = '0;
            end
        endcase
        if (relock && (state_q != LK_HOLD)) begin
            state_d = LK_SETTLE;
            cnt_d   = '0;
        end
        if (pll_reset) begin
            state_d = LK_HOLD;
            cnt_d   = '0;
        end
        lock_d = (state_d == LK_LOCKED);
    end

endmodule

// File: rtl/pll_mdrp_responder.sv
// MDRP responder: opcode decode, auto-incrementing address, byte register
// file with a read-only STATUS register, and emulated PLL lock.
module pll_mdrp_responder
    import pll_mdrp_pkg::*;
#(
    parameter int unsigned        ADDR_W      = 5,
    parameter int unsigned        LOCK_CYCLES = 64,
    parameter logic [ADDR_W-1:0]  MULTI_ADDR  = 5'h08,
    parameter logic [7:0]         RESET_MULTI = 8'd35
) (
    input  logic       mdclk,
    input  logic       reset,
    input  logic       pll_reset,
    input  logic [1:0] mdopc,
    input  logic       mdainc,
    input  logic [7:0] mdwdi,
    output logic [7:0] mdrdo,
    output logic       lock,
    output logic [7:0] cfg_multi
);

    localparam int unsigned       NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] STATUS = ADDR_W'(status_addr(ADDR_W));

    logic [ADDR_W-1:0] addr;
    logic [7:0]        regs [NREG];
    logic              wr_eff;

    assign wr_eff    = (mdopc == OP_WRITE) && (addr != STATUS);
    assign cfg_multi = regs[MULTI_ADDR];

    // Address register: load on ADDR, optional post-access increment.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            addr <= '0;
        end else if (mdopc == OP_ADDR) begin
            addr <= mdwdi[ADDR_W-1:0];
        end else if ((mdopc == OP_WRITE || mdopc == OP_READ) && mdainc) begin
            addr <= addr + ADDR_W'(1);
        end
    end

    // Register file; STATUS writes are dropped.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= (ADDR_W'(i) == MULTI_ADDR) ? RESET_MULTI : 8'h00;
            end
        end else if (wr_eff) begin
            regs[addr] <= mdwdi;
        end
    end

    // Read data register, held between READs.
    always_ff @(posedge mdclk) begin
        if (reset) begin
            mdrdo <= 8'h00;
        end else if (mdopc == OP_READ) begin
            mdrdo <= (addr == STATUS) ? {7'b0, lock} : regs[addr];
        end
    end

    pll_mdrp_lock_timer #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock_timer (
        .mdclk    (mdclk),
        .reset    (reset),
        .pll_reset(pll_reset),
        .relock   (wr_eff),
        .lock     (lock)
    );

endmodule

// File: tb/tb_pll_mdrp_responder.sv
// Bench for pll_mdrp_responder: behavioural model plus directed literal checks.
module tb_pll_mdrp_responder;

    localparam int LOCK_CYCLES = 64;
    localparam int NREG        = 32;
    localparam int STATUS      = 31;

    logic       mdclk = 1'b0;
    logic       reset;
    logic       pll_reset;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo;
    logic       lock;
    logic [7:0] cfg_multi;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Model state
    logic [7:0] m_mem [NREG];
    int         m_addr;
    logic [7:0] m_rd;
    bit         m_lock;
    bit         m_hold;
    int         m_elapsed;
    bit         m_wr_eff;
    bit         m_old_lock;

    pll_mdrp_responder dut (
        .mdclk    (mdclk),
        .reset    (reset),
        .pll_reset(pll_reset),
        .mdopc    (mdopc),
        .mdainc   (mdainc),
        .mdwdi    (mdwdi),
        .mdrdo    (mdrdo),
        .lock     (lock),
        .cfg_multi(cfg_multi)
    );

    always #5 mdclk = ~mdclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register file semantics and settle time counted in edges.
    always @(posedge mdclk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) m_mem[i] = (i == 8) ? 8'd35 : 8'd0;
            m_addr = 0; m_rd = 8'd0; m_lock = 0; m_hold = 0; m_elapsed = 0;
        end else begin
            m_wr_eff   = (mdopc == 2'b10) && (m_addr != STATUS);
            m_old_lock = m_lock;
            case (mdopc)
                2'b01: m_addr = int'(mdwdi) % NREG;
                2'b10: begin
                    if (m_addr != STATUS) m_mem[m_addr] = mdwdi;
                    if (mdainc) m_addr = (m_addr + 1) % NREG;
                end
                2'b11: begin
                    m_rd = (m_addr == STATUS) ? {7'b0, m_old_lock} : m_mem[m_addr];
                    if (mdainc) m_addr = (m_addr + 1) % NREG;
                end
                default: ;
            endcase
            if (pll_reset) begin
                m_hold = 1; m_lock = 0;
            end else if (m_hold) begin
                m_hold = 0; m_elapsed = 0; m_lock = 0;
            end else if (m_wr_eff) begin
                m_elapsed = 0; m_lock = 0;
            end else if (!m_lock) begin
                m_elapsed++;
                if (m_elapsed >= LOCK_CYCLES) m_lock = 1;
            end
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge mdclk) begin
        if (chk_en) begin
            check("model_mdrdo", 32'(mdrdo), 32'(m_rd));
            check("model_lock", 32'(lock), 32'(m_lock));
            check("model_cfg_multi", 32'(cfg_multi), 32'(m_mem[8]));
        end
    end

    task automatic cyc(input logic [1:0] op, input logic ai, input logic [7:0] d);
        mdopc = op; mdainc = ai; mdwdi = d;
        @(negedge mdclk);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 8'h00);
    endtask

    task automatic wait_lock();
        for (int i = 0; i < 300 && lock !== 1'b1; i++) cyc(2'b00, 1'b0, 8'h00);
        check("wait_lock", 32'(lock), 32'd1);
    endtask

    initial begin
        reset = 1'b1; pll_reset = 1'b0; mdopc = 2'b00; mdainc = 1'b0; mdwdi = 8'h00;
        @(negedge mdclk); @(negedge mdclk); @(negedge mdclk);
        reset = 1'b0;
        chk_en = 1;
        check("reset_mdrdo", 32'(mdrdo), 32'd0);
        check("reset_lock", 32'(lock), 32'd0);
        check("reset_cfg_multi", 32'(cfg_multi), 32'd35);

        // Reads after reset, then lock timing from reset release
        cyc(2'b01, 1'b0, 8'h08);
        cyc(2'b11, 1'b0, 8'h00);
        check("read_multi_reset", 32'(mdrdo), 32'd35);
        cyc(2'b01, 1'b0, 8'h1F);
        cyc(2'b11, 1'b0, 8'h00);
        check("read_status_settle", 32'(mdrdo), 32'd0);
        nops(59);
        check("lock_before_64", 32'(lock), 32'd0);
        nops(1);
        check("lock_at_64", 32'(lock), 32'd1);
        cyc(2'b11, 1'b0, 8'h00);
        check("read_status_locked", 32'(mdrdo), 32'd1);

        // Top address and wrap
        cyc(2'b01, 1'b0, 8'h00);
        cyc(2'b10, 1'b0, 8'h5A);
        check("relock_drop", 32'(lock), 32'd0);
        cyc(2'b01, 1'b0, 8'h1E);
        cyc(2'b10, 1'b1, 8'hA5);
        cyc(2'b11, 1'b1, 8'h00);
        check("read_status_wrap", 32'(mdrdo), 32'd0);
        cyc(2'b11, 1'b0, 8'h00);
        check("read_after_wrap", 32'(mdrdo), 32'h5A);
        cyc(2'b01, 1'b0, 8'h3E);
        cyc(2'b11, 1'b0, 8'h00);
        check("read_1e_upper_ignored", 32'(mdrdo), 32'hA5);

        // Burst write then streaming read
        cyc(2'b01, 1'b0, 8'h00);
        cyc(2'b10, 1'b1, 8'h11);
        cyc(2'b10, 1'b1, 8'h22);
        cyc(2'b10, 1'b1, 8'h33);
        cyc(2'b10, 1'b1, 8'h44);
        cyc(2'b01, 1'b0, 8'h00);
        cyc(2'b11, 1'b1, 8'h00); check("burst_rd0", 32'(mdrdo), 32'h11);
        cyc(2'b11, 1'b1, 8'h00); check("burst_rd1", 32'(mdrdo), 32'h22);
        cyc(2'b11, 1'b1, 8'h00); check("burst_rd2", 32'(mdrdo), 32'h33);
        cyc(2'b11, 1'b1, 8'h00); check("burst_rd3", 32'(mdrdo), 32'h44);
        cyc(2'b00, 1'b0, 8'h00); check("mdrdo_hold", 32'(mdrdo), 32'h44);

        // Multiplier write relock
        wait_lock();
        cyc(2'b01, 1'b0, 8'h08);
        cyc(2'b10, 1'b0, 8'd40);
        check("multi_write", 32'(cfg_multi), 32'd40);
        check("multi_relock_drop", 32'(lock), 32'd0);
        nops(63);
        check("multi_lock_63", 32'(lock), 32'd0);
        nops(1);
        check("multi_lock_64", 32'(lock), 32'd1);
        cyc(2'b01, 1'b0, 8'h1F);
        cyc(2'b10, 1'b0, 8'h77);
        check("status_write_keeps_lock", 32'(lock), 32'd1);

        // pll_reset held 10 cycles with a write inside
        pll_reset = 1'b1;
        cyc(2'b01, 1'b0, 8'h05);
        check("pllrst_lock_0", 32'(lock), 32'd0);
        cyc(2'b10, 1'b0, 8'h9C);
        check("pllrst_lock_1", 32'(lock), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(2'b00, 1'b0, 8'h00);
            check("pllrst_lock_hold", 32'(lock), 32'd0);
        end
        pll_reset = 1'b0;
        nops(64);
        check("pllrst_lock_before", 32'(lock), 32'd0);
        nops(1);
        check("pllrst_lock_after", 32'(lock), 32'd1);
        cyc(2'b11, 1'b0, 8'h00);
        check("pllrst_write_stored", 32'(mdrdo), 32'h9C);

        // Reset in the middle of a burst
        cyc(2'b01, 1'b0, 8'h00);
        cyc(2'b10, 1'b1, 8'hDE);
        cyc(2'b10, 1'b1, 8'hAD);
        reset = 1'b1;
        cyc(2'b10, 1'b1, 8'hBE);
        reset = 1'b0;
        check("midrst_mdrdo", 32'(mdrdo), 32'd0);
        check("midrst_multi", 32'(cfg_multi), 32'd35);
        check("midrst_lock", 32'(lock), 32'd0);
        cyc(2'b11, 1'b1, 8'h00); check("midrst_reg0", 32'(mdrdo), 32'd0);
        cyc(2'b11, 1'b1, 8'h00); check("midrst_reg1", 32'(mdrdo), 32'd0);
        cyc(2'b01, 1'b0, 8'h05);
        cyc(2'b11, 1'b0, 8'h00); check("midrst_reg5", 32'(mdrdo), 32'd0);

        // Randomised traffic with quiet stretches so lock is reached
        for (int seg = 0; seg < 10; seg++) begin
            for (int i = 0; i < 150; i++) begin
                int r;
                r = $urandom_range(0, 99);
                pll_reset = ($urandom_range(0, 99) < 3);
                reset     = ($urandom_range(0, 499) == 0);
                cyc((r < 55) ? 2'b00 : (r < 65) ? 2'b01 : (r < 82) ? 2'b10 : 2'b11,
                    1'($urandom_range(0, 1)), 8'($urandom));
            end
            pll_reset = 1'b0;
            reset     = 1'b0;
            for (int i = 0; i < 70; i++) begin
                cyc(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
